multiplier_control: RTL and testbench

//   Sequencing FSM for the 8x8 two's-complement shift-add multiplier datapath.

---
 rtl/multiplier_control.sv | 127 ++++++++++++
 tb/tb_multiplier_control.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/multiplier_control.sv
// Sequencing FSM for a two's-complement shift-add multiplier.
// Walks the datapath through one clear cycle and WIDTH add/shift iterations.
// On the final (sign-bit) iteration the add becomes a subtract.
// It holds the product until Run is released.
// Outputs are decoded combinationally from the registered state, the iteration count and M.
module multiplier_control #(
    parameter int WIDTH = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Ld_B,
    output logic Clr_A,
    output logic Ld_A,
    output logic Fn,
    output logic Shift_En,
    output logic Busy,
    output logic Done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t          state_reg;
    logic [CW-1:0]   count_reg;
    // Set once Run has been seen low. A start needs a fresh rising request.
    // So a Run level held through a reset cannot launch an operation.
    logic            armed_reg;

    logic            last_iter;
    assign last_iter = (count_reg == LAST);

    // State, iteration count and start-arming register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            armed_reg <= 1'b0;
        end else begin
            if (!Run) begin
                armed_reg <= 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (Run && armed_reg) begin
                        state_reg <= CLEAR;
                        armed_reg <= 1'b0;
                    end
                end
                CLEAR: begin
                    count_reg <= '0;
                    state_reg <= ADD;
                end
                ADD: begin
                    state_reg <= SHIFT;
                end
                SHIFT: begin
                    if (last_iter) begin
                        state_reg <= HOLD;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                        state_reg <= ADD;
                    end
                end
                HOLD: begin
                    if (!Run) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    count_reg <= '0;
                end
            endcase
        end
    end

    // Strobe decode from the current state.
    // Run outranks the load/clear request in IDLE.
    always_comb begin
        Ld_B     = 1'b0;
        Clr_A    = 1'b0;
        Ld_A     = 1'b0;
        Fn       = 1'b0;
        Shift_En = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!Run && ClearA_LoadB) begin
                    Ld_B  = 1'b1;
                    Clr_A = 1'b1;
                end
            end
            CLEAR: begin
                Clr_A = 1'b1;
                Busy  = 1'b1;
            end
            ADD: begin
                Ld_A = M;
                Fn   = M & last_iter;
                Busy = 1'b1;
            end
            SHIFT: begin
                Shift_En = 1'b1;
                Busy     = 1'b1;
            end
            HOLD: begin
                Done = 1'b1;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multiplier_control.sv
// Directed testbench for multiplier_control.
// Pairs the FSM with a behavioural X:A:B register and 9-bit adder model.
// The multiplicand S is driven on the switch bus sw.
module tb_multiplier_control;

    logic Clk = 1'b0;
    logic Reset, Run, ClearA_LoadB, M;
    logic Ld_B, Clr_A, Ld_A, Fn, Shift_En, Busy, Done;

    logic [7:0] sw;
    logic       x_reg;
    logic [7:0] a_reg, b_reg;

    int checks = 0;
    int errors = 0;

    int lda_cnt, sh_cnt, fn_cnt, busy_cnt, excl_cnt;

    multiplier_control #(.WIDTH(8)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
        .Ld_B(Ld_B), .Clr_A(Clr_A), .Ld_A(Ld_A), .Fn(Fn), .Shift_En(Shift_En),
        .Busy(Busy), .Done(Done)
    );

    always #5 Clk = ~Clk;

    assign M = b_reg[0];

    // Behavioural datapath plus strobe statistics.
    // The statistics restart on every B load.
    logic [8:0] sum9;
    always_comb begin
        if (Fn) sum9 = {a_reg[7], a_reg} - {sw[7], sw};
        else    sum9 = {a_reg[7], a_reg} + {sw[7], sw};
    end

    always @(posedge Clk) begin
        if (Clr_A) begin
            a_reg <= 8'h00;
            x_reg <= 1'b0;
        end
        if (Ld_A) {x_reg, a_reg} <= sum9;
        if (Shift_En) begin
            a_reg <= {x_reg, a_reg[7:1]};
            b_reg <= {a_reg[0], b_reg[7:1]};
        end
        if (Ld_B) b_reg <= sw;

        if (Ld_B) begin
            lda_cnt <= 0; sh_cnt <= 0; fn_cnt <= 0; busy_cnt <= 0; excl_cnt <= 0;
        end else begin
            lda_cnt  <= lda_cnt + int'(Ld_A);
            sh_cnt   <= sh_cnt + int'(Shift_En);
            fn_cnt   <= fn_cnt + int'(Ld_A && Fn);
            busy_cnt <= busy_cnt + int'(Busy);
            if ((int'(Ld_A) + int'(Shift_En) + int'(Ld_B)) > 1 || (Clr_A && (Ld_A || Shift_En)))
                excl_cnt <= excl_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (Done !== 1'b1 && cyc < 40) begin
            @(negedge Clk);
            cyc++;
        end
    endtask

    // Load B, start with multiplicand s, and check the product, latency and strobe counts.
    task automatic do_op(input string tag, input logic [7:0] bval, input logic [7:0] sval,
                         input logic [15:0] prod, input int exp_lda, input int exp_fn);
        int cyc;
        @(negedge Clk);
        sw = bval; ClearA_LoadB = 1'b1;
        @(negedge Clk);
        ClearA_LoadB = 1'b0; sw = sval; Run = 1'b1;
        wait_done(cyc);
        check({tag, "_latency"}, cyc, 18);
        check({tag, "_product"}, {x_reg, a_reg, b_reg}, {x_reg, prod});
        check({tag, "_sign_x"}, x_reg, prod[15]);
        check({tag, "_lda_cnt"}, lda_cnt, exp_lda);
        check({tag, "_fn_cnt"}, fn_cnt, exp_fn);
        check({tag, "_shift_cnt"}, sh_cnt, 8);
        check({tag, "_busy_cnt"}, busy_cnt, 17);
        check({tag, "_exclusive"}, excl_cnt, 0);
        Run = 1'b0;
        @(negedge Clk);
        check({tag, "_done_drop"}, {Done, Busy}, 2'b00);
        $display("op %s B=%02h S=%02h -> product=%04h cycles=%0d", tag, bval, sval, {a_reg, b_reg}, cyc);
    endtask

    initial begin
        int cyc;
        Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; sw = 8'h00;
        x_reg = 1'b0; a_reg = 8'h00; b_reg = 8'h00;
        repeat (3) @(negedge Clk);
        check("reset_outputs", {Ld_B, Clr_A, Ld_A, Fn, Shift_En, Busy, Done}, 7'b0);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        check("idle_outputs", {Ld_B, Clr_A, Ld_A, Fn, Shift_En, Busy, Done}, 7'b0);

        // Reset arriving while a shift is under way.
        sw = 8'h05; ClearA_LoadB = 1'b1;
        @(negedge Clk);
        ClearA_LoadB = 1'b0; sw = 8'h03; Run = 1'b1;
        cyc = 0;
        while (Shift_En !== 1'b1 && cyc < 10) begin
            @(negedge Clk);
            cyc++;
        end
        check("reach_shift", Shift_En, 1'b1);
        Reset = 1'b1;
        @(negedge Clk);
        check("reset_mid_shift", {Ld_B, Clr_A, Ld_A, Fn, Shift_En, Busy, Done}, 7'b0);
        Reset = 1'b0;
        repeat (5) @(negedge Clk);
        check("no_restart_run_held", {Busy, Done, Clr_A}, 3'b000);
        Run = 1'b0;
        @(negedge Clk);
        Run = 1'b1;
        @(negedge Clk);
        check("restart_clear", {Busy, Clr_A}, 2'b11);
        wait_done(cyc);
        check("restart_done", Done, 1'b1);
        Run = 1'b0;
        @(negedge Clk);
        $display("reset-mid-shift sequence complete");

        do_op("pos_pos", 8'h07, 8'h3B, 16'h019D, 3, 0);
        do_op("neg_b", 8'hF9, 8'h3B, 16'hFE63, 6, 1);
        do_op("neg_s", 8'h3B, 8'hF9, 16'hFE63, 5, 0);
        do_op("min_min", 8'h80, 8'h80, 16'h4000, 1, 1);
        do_op("zero_b", 8'h00, 8'h5A, 16'h0000, 0, 0);

        // Run together with ClearA_LoadB in IDLE; Run held through HOLD.
        @(negedge Clk);
        Run = 1'b1; ClearA_LoadB = 1'b1; sw = 8'hAA;
        #1;
        check("run_prio_no_ldb", {Ld_B, Clr_A}, 2'b00);
        @(negedge Clk);
        check("run_prio_clear", {Busy, Clr_A, Ld_B}, 3'b110);
        wait_done(cyc);
        check("prio_latency", cyc, 17);
        repeat (5) @(negedge Clk);
        check("hold_no_restart", {Done, Busy, Ld_B, Clr_A}, 4'b1000);
        ClearA_LoadB = 1'b0; Run = 1'b0;
        @(negedge Clk);
        check("hold_exit", {Done, Busy}, 2'b00);
        $display("run-priority / hold sequence complete");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
